// File: rtl/cache_write_buffer_pkg.sv
// Shared types for the cache write buffer: FSM state encoding, FIFO entry layout
// and the word-alignment helper.
package cache_write_buffer_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WB_ENTRY = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_DRAIN = 2'd1,
        WB_READ  = 2'd2,
        WB_RDATA = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                     input int low_bits);
        logic [ADDR_W-1:0] mask;
        mask = ~((32'd1 << low_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_write_buffer_if.sv
// Word bus shared by the cache side and the memory side of the write buffer.
interface cache_write_buffer_if;

    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ready;

    modport master (output re, we, addr, data_out, input data_in, ready);
    modport slave  (input re, we, addr, data_out, output data_in, ready);

endinterface

// File: rtl/cache_write_buffer_fifo.sv
// Circular store of posted writes with a combinational youngest-match lookup,
// so pending data can be forwarded to reads.
module cache_write_buffer_fifo
    import cache_write_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic [ADDR_W-1:0]     query_addr,
    output logic                  hit,
    output logic [DATA_W-1:0]     hit_data,
    output wb_entry_t             head_entry,
    output wb_entry_t             next_entry,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WB_ENTRY-1:0]   store_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic [DEPTH_LOG2-1:0] idx;
    wb_entry_t             probe;

    // NOTE: the entry storage has no reset; validity comes from the pointers and
    // count, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            store_q[tail_q] <= push_entry;
        end
    end

    assign count_d = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!res) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            count_q <= count_d;
            empty   <= (count_d == '0);
            full    <= (count_d == (DEPTH_LOG2+1)'(DEPTH));
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        probe    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx   = head_q + DEPTH_LOG2'(k);
            probe = wb_entry_t'(store_q[idx]);
            if (((DEPTH_LOG2+1)'(k) < count_q) && (probe.addr == query_addr)) begin
                hit      = 1'b1;
                hit_data = probe.data;
            end
        end
    end

    assign head_entry = wb_entry_t'(store_q[head_q]);
    assign next_entry = wb_entry_t'(store_q[head_q + 1'b1]);
    assign count      = count_q;

endmodule

// File: rtl/cache_write_buffer.sv
// Posted write buffer: absorbs cache writes in one cycle, drains them in order,
// forwards reads that hit pending entries and sends misses straight to memory.
module cache_write_buffer
    import cache_write_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2    = 2,
    parameter int ADDR_MASK_LOW = 2
) (
    input  logic                 clk,
    input  logic                 res,
    cache_write_buffer_if.slave  up,
    cache_write_buffer_if.master mem,
    output logic                 empty,
    output logic                 full
);

    wb_state_e           state_q;
    wb_state_e           state_d;
    logic                push;
    logic                pop;
    logic                hit;
    logic                is_read;
    logic                read_miss;
    logic [ADDR_W-1:0]   up_addr_al;
    logic [DATA_W-1:0]   hit_data;
    wb_entry_t           head_entry;
    wb_entry_t           next_entry;
    logic [DEPTH_LOG2:0] count;

    logic                mem_re_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic [DATA_W-1:0]   up_data_q;

    assign up_addr_al = align_addr(up.addr, ADDR_MASK_LOW);
    // A simultaneous re/we is treated as a write.
    assign is_read    = up.re & ~up.we;
    assign push       = up.we & ~full;
    assign read_miss  = is_read & ~hit;
    assign up.ready   = push | (is_read & (hit | (state_q == WB_RDATA)));

    cache_write_buffer_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk        (clk),
        .res        (res),
        .push       (push),
        .push_entry ('{addr: up_addr_al, data: up.data_out}),
        .pop        (pop),
        .query_addr (up_addr_al),
        .hit        (hit),
        .hit_data   (hit_data),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    // A read miss jumps ahead of pending drains: by definition no queued write
    // targets that word.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                if (read_miss)   state_d = WB_READ;
                else if (!empty) state_d = WB_DRAIN;
            end
            WB_DRAIN: begin
                if (mem.ready) begin
                    pop = 1'b1;
                    if (read_miss)                             state_d = WB_READ;
                    else if (count > (DEPTH_LOG2+1)'(1))       state_d = WB_DRAIN;
                    else                                       state_d = WB_IDLE;
                end
            end
            WB_READ: begin
                if (mem.ready) state_d = WB_RDATA;
            end
            WB_RDATA: state_d = WB_IDLE;
            default:  state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= WB_IDLE;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            up_data_q  <= '0;
        end else begin
            state_q  <= state_d;
            mem_re_q <= (state_d == WB_READ);
            mem_we_q <= (state_d == WB_DRAIN);

            // After a pop the new head is the entry behind the one just written.
            if (state_d == WB_READ && state_q != WB_READ) begin
                mem_addr_q <= up_addr_al;
            end else if (state_d == WB_DRAIN && state_q == WB_IDLE) begin
                mem_addr_q <= head_entry.addr;
                mem_data_q <= head_entry.data;
            end else if (state_d == WB_DRAIN && pop) begin
                mem_addr_q <= next_entry.addr;
                mem_data_q <= next_entry.data;
            end

            if (state_q == WB_RDATA)    up_data_q <= mem.data_in;
            else if (is_read && hit)    up_data_q <= hit_data;
        end
    end

    assign mem.re       = mem_re_q;
    assign mem.we       = mem_we_q;
    assign mem.addr     = mem_addr_q;
    assign mem.data_out = mem_data_q;
    assign up.data_in   = up_data_q;

endmodule

// File: doc/cache_write_buffer.md
Name: cache_write_buffer

Overview:
Posted write buffer between the Cache memory-side bus (dbOut_*) and main memory (DummyMem or the real controller). Cache writes are absorbed into a small FIFO in one cycle, then drained to memory in order in the background. Reads that hit a pending entry are forwarded from the buffer; reads that miss bypass the queue to memory. Both sides use the same re/we/addr/dataOut/dataIn/ready word bus.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO entry count (DEPTH = 4 by default); minimum 1.
ADDR_MASK_LOW, 2, low address bits ignored; word-aligned address = {addr[31:2], 2'd0}.

Ports:
clk  in  1  clock, rising edge
res  in  1  reset; synchronous, active-low (res=0 at a rising clk edge resets)
up_re  in  1  read request from Cache
up_we  in  1  write request from Cache
up_addr  in  32  byte address; bits [1:0] ignored
up_dataOut  in  32  write data from Cache
up_dataIn  out  32  read data to Cache; registered
up_ready  out  1  request accepted at this edge; combinational
mem_re  out  1  read request to memory; registered
mem_we  out  1  write request to memory; registered
mem_addr  out  32  word-aligned memory address
mem_dataOut  out  32  write data to memory
mem_dataIn  in  32  memory read data; valid the cycle after read acceptance
mem_ready  in  1  memory accepts the current request at this edge
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds DEPTH entries

Behaviour:
- Bus rule, both sides: a transfer completes at a rising edge with (re|we)=1 and ready=1. Read data is valid during the whole next cycle. The requester holds re, we, addr and dataOut stable until ready.
- up_re and up_we both high is illegal. Bench asserts on it; RTL treats it as a write.
- Reset (res=0 at an edge): FIFO emptied, state IDLE, mem_re=0, mem_we=0, mem_addr=0, mem_dataOut=0, up_dataIn=0, empty=1, full=0. Reset mid-drain or mid-read abandons the transaction; the memory side sees re/we low from the next cycle.
- Write accept: up_ready = up_we & ~full. full uses the registered count, so no write is accepted while full, even in a cycle when the head pops. Entry stored = {aligned addr, data}.
- Read forward: up_re is compared against all valid entries. On a hit, up_ready=1 in the same cycle. up_dataIn is loaded at that edge with the youngest matching entry's data. Latency is 1 cycle, and forwarding works in any state.
- Read miss: up_ready=0. The FSM services the miss through READ/RDATA, ahead of any pending drain. Reordering is safe because no pending write matches that address.
- FSM states:
  IDLE: on read miss go to READ, latching the addr. Else, if not empty, go to DRAIN, loading mem_addr/mem_dataOut from the head.
  DRAIN: mem_we=1. At a mem_ready edge, pop the head. Then go to READ if a read miss is pending, else stay in DRAIN if entries remain, else go to IDLE.
  READ: mem_re=1. At a mem_ready edge go to RDATA.
  RDATA: capture mem_dataIn into up_dataIn; up_ready=1 for the pending up_re; then go to IDLE.
- DummyMem (ready tied 1) miss timeline: c0 detect; c1 mem_re; c2 RDATA with up_ready=1; c3 up_dataIn valid.
- Enqueue and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH. Duplicate addresses are allowed and not coalesced; the youngest wins forwarding, and all copies drain in order.
- full/empty are registered, derived from a DEPTH_LOG2+1 bit count.

Decomposition:
- DataBus.vh gains the state encodings `WB_IDLE/`WB_DRAIN/`WB_READ/`WB_RDATA and the `WB_ENTRY width macro. Existing `MEM_ACCESS definitions are unchanged.
- One sub-module, write_buffer_fifo, owns the circular storage, pointers and count. It provides a combinational youngest-match output (hit, hitData) for a query address.
- cache_write_buffer keeps the FSM and bus muxing.

Test Plan:
- Reset then idle, with DummyMem behind the buffer: res=0 for one edge → empty=1, full=0, mem_re=mem_we=0, up_dataIn=0.
- Write 0x0000_0010←0xDEAD_BEEF, then read 0x12 next cycle → up_ready=1 immediately, and 0xDEAD_BEEF on up_dataIn the following cycle with no mem_re. Later the memory word at 0x10 = 0xDEAD_BEEF.
- Fill 4 writes with mem_ready held 0 → full=1; a 5th up_we gets up_ready=0. Release mem_ready → drained in order 0x0,0x4,0x8,0xC; the 5th is accepted once count<4.
- Write 0x20←1 then 0x20←2, then read 0x20 → forwarded 2. Memory sees both writes in order and ends at 2.
- Read miss at 0x0 on DummyMem preset bytes 02,03,04,05, with 2 writes pending → mem_re precedes the remaining mem_we; up_dataIn=0x0203_0405 at c3.
- Assert res=0 during DRAIN with 3 entries → the next cycle has mem_we=0 and empty=1, and no further memory writes occur.
